// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU front-panel controller: FSM states and ALU opcodes.
package alu_ctrl_pkg;

   localparam int unsigned OPCODE_W = 6;

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      EXEC    = 3'd3,
      SHOW    = 3'd4
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_ADD = 6'b100000;
   localparam logic [OPCODE_W-1:0] OP_SUB = 6'b100010;
   localparam logic [OPCODE_W-1:0] OP_AND = 6'b100100;
   localparam logic [OPCODE_W-1:0] OP_OR  = 6'b100101;
   localparam logic [OPCODE_W-1:0] OP_XOR = 6'b100110;
   localparam logic [OPCODE_W-1:0] OP_NOR = 6'b100111;
   localparam logic [OPCODE_W-1:0] OP_SRA = 6'b000011;
   localparam logic [OPCODE_W-1:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/btn_debounce.sv
// 2-FF synchronizer, stability-counter debouncer and single-cycle press pulse
// for one raw push button.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

   logic          sync1, sync2;
   logic          level_q;
   logic [CW-1:0] count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         count   <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_q <= level;
         if (sync2 == level) begin
            count <= '0;
         end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync2;
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   // Combinational edge so the load lands one edge after the level flips.
   assign press = level & ~level_q;

endmodule

// File: rtl/alu_load_sequencer.sv
// Sequences A, B and opcode loads from a shared switch bus with one enter
// button, then captures the combinational ALU result for display.
module alu_load_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned N_BITS          = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic                i_clock,
   input  logic                i_reset_n,
   input  logic [N_BITS-1:0]   i_data_bus,
   input  logic                i_enter,
   input  logic                i_clear,
   input  logic [N_BITS-1:0]   i_alu_result,
   output logic [N_BITS-1:0]   o_data_a,
   output logic [N_BITS-1:0]   o_data_b,
   output logic [OPCODE_W-1:0] o_opcode,
   output logic [N_BITS-1:0]   o_result,
   output logic                o_result_valid,
   output logic [2:0]          o_state
);

   state_t state, next_state;
   logic   press;
   logic   enter_level;
   logic   clear_s1, clear_s2;
   logic   load_a, load_b, load_op, load_res;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
      .clock   (i_clock),
      .reset_n (i_reset_n),
      .raw     (i_enter),
      .level   (enter_level),
      .press   (press)
   );

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         clear_s1 <= 1'b0;
         clear_s2 <= 1'b0;
      end else begin
         clear_s1 <= i_clear;
         clear_s2 <= clear_s1;
      end
   end

   always_comb begin
      next_state = state;
      load_a     = 1'b0;
      load_b     = 1'b0;
      load_op    = 1'b0;
      load_res   = 1'b0;
      if (clear_s2) begin
         next_state = WAIT_A;
      end else begin
         case (state)
            WAIT_A:  if (press) begin load_a  = 1'b1; next_state = WAIT_B;  end
            WAIT_B:  if (press) begin load_b  = 1'b1; next_state = WAIT_OP; end
            WAIT_OP: if (press) begin load_op = 1'b1; next_state = EXEC;    end
            EXEC:    begin load_res = 1'b1; next_state = SHOW; end
            SHOW:    if (press) next_state = WAIT_A;
            default: next_state = WAIT_A;
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state          <= WAIT_A;
         o_data_a       <= '0;
         o_data_b       <= '0;
         o_opcode       <= '0;
         o_result       <= '0;
         o_result_valid <= 1'b0;
      end else begin
         state <= next_state;
         if (clear_s2) begin
            o_data_a       <= '0;
            o_data_b       <= '0;
            o_opcode       <= '0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
         end else begin
            if (load_a) begin
               o_data_a       <= i_data_bus;
               o_result_valid <= 1'b0;
            end
            if (load_b)  o_data_b <= i_data_bus;
            if (load_op) o_opcode <= i_data_bus[OPCODE_W-1:0];
            if (load_res) begin
               o_result       <= i_alu_result;
               o_result_valid <= 1'b1;
            end
         end
      end
   end

   assign o_state = state;

endmodule
